// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. It inserts load-use bubbles, bypasses same-cycle write-back
// data into the captured operands, and keeps saturating stall and flush counters.
module id_ex_stage #(
  parameter int XLEN   = 64,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              valid_q, valid_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]   rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [XLEN-1:0]   imm_q, imm_d, pc_q, pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              mem_read_q, mem_read_d, reg_write_q, reg_write_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              hazard;
  logic [XLEN-1:0]   opnd1, opnd2;

  // The regfile writes on the same edge we capture, so its read port is still stale.
  function automatic logic [XLEN-1:0] sel_operand(input logic [4:0]      idx,
                                                  input logic [XLEN-1:0] rdata,
                                                  input logic            wb_we,
                                                  input logic [4:0]      wb_idx,
                                                  input logic [XLEN-1:0] wb_val);
    if (idx == 5'd0)                    return '0;
    else if (wb_we && (wb_idx == idx))  return wb_val;
    else                                return rdata;
  endfunction

  assign hazard = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
                  ((rd_q == id_rs1) | (id_uses_rs2 & (rd_q == id_rs2)));
  assign stall_id = hazard & ~flush & ~reset;

  assign opnd1 = sel_operand(id_rs1, id_rdata1, wb_reg_write, wb_rd, wb_data);
  assign opnd2 = sel_operand(id_rs2, id_rdata2, wb_reg_write, wb_rd, wb_data);

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    imm_d       = imm_q;
    pc_d        = pc_q;
    ctrl_d      = ctrl_q;
    mem_read_d  = mem_read_q;
    reg_write_d = reg_write_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (flush || hazard) begin
      // Bubble: only the qualifying bits are cleared, data fields hold.
      valid_d     = 1'b0;
      ctrl_d      = '0;
      mem_read_d  = 1'b0;
      reg_write_d = 1'b0;
      if (flush) begin
        if (id_valid && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
      end else begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      valid_d     = id_valid;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      rdata1_d    = opnd1;
      rdata2_d    = opnd2;
      imm_d       = id_imm;
      pc_d        = id_pc;
      ctrl_d      = id_ctrl;
      mem_read_d  = id_mem_read;
      reg_write_d = id_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      ctrl_q      <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      ctrl_q      <= ctrl_d;
      mem_read_q  <= mem_read_d;
      reg_write_q <= reg_write_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_rs1       = rs1_q;
  assign ex_rs2       = rs2_q;
  assign ex_rd        = rd_q;
  assign ex_rdata1    = rdata1_q;
  assign ex_rdata2    = rdata2_q;
  assign ex_imm       = imm_q;
  assign ex_pc        = pc_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_reg_write = reg_write_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic, all checked against
// a cycle-level reference model of the EX register and the event counters.
module tb_id_ex_stage;
  localparam int XLEN = 64, CTRL_W = 8, CNT_W = 4;
  localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, id_valid, id_uses_rs2, id_mem_read, id_reg_write, wb_reg_write, flush;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [XLEN-1:0] id_rdata1, id_rdata2, id_imm, id_pc, wb_data;
  logic [CTRL_W-1:0] id_ctrl;
  logic stall_id, ex_valid, ex_mem_read, ex_reg_write;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [XLEN-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .flush(flush), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt));

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what EX should hold, plus the two event tallies.
  logic m_valid, m_mem_read, m_reg_write, m_data_known;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [63:0] m_rdata1, m_rdata2, m_imm, m_pc;
  logic [CTRL_W-1:0] m_ctrl;
  longint m_stalls = 0, m_flushes = 0;
  logic obs_stall;

  function automatic logic [63:0] expect_operand(input logic [4:0] idx, input logic [63:0] rf);
    if (idx == 0) return 64'd0;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return rf;
  endfunction

  function automatic logic model_hazard();
    if (!(m_valid && m_mem_read && m_rd != 0 && id_valid)) return 1'b0;
    return (m_rd == id_rs1) || (id_uses_rs2 && m_rd == id_rs2);
  endfunction

  // One clock: check stall_id on the driven inputs, clock, advance the model, check EX.
  task automatic step();
    logic hz, exp_stall;
    #1;
    hz = model_hazard();
    exp_stall = hz && !flush && !reset;
    obs_stall = stall_id;
    chk("stall_id", {63'd0, stall_id}, {63'd0, exp_stall});
    @(posedge clk);
    if (reset) begin
      {m_valid, m_mem_read, m_reg_write, m_ctrl} = '0;
      {m_rs1, m_rs2, m_rd, m_rdata1, m_rdata2, m_imm, m_pc} = '0;
      m_stalls = 0; m_flushes = 0; m_data_known = 1'b1;
    end else if (flush || hz) begin
      {m_valid, m_mem_read, m_reg_write, m_ctrl} = '0;
      m_data_known = 1'b0;
      if (flush) begin
        if (id_valid && m_flushes < CNT_MAX) m_flushes++;
      end else if (m_stalls < CNT_MAX) m_stalls++;
    end else begin
      m_valid = id_valid; m_mem_read = id_mem_read; m_reg_write = id_reg_write;
      m_ctrl = id_ctrl; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_rdata1 = expect_operand(id_rs1, id_rdata1);
      m_rdata2 = expect_operand(id_rs2, id_rdata2);
      m_imm = id_imm; m_pc = id_pc; m_data_known = 1'b1;
    end
    #1;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m_valid});
    chk("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, m_mem_read});
    chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, m_reg_write});
    chk("ex_ctrl", {56'd0, ex_ctrl}, {56'd0, m_ctrl});
    chk("stall_cnt", {60'd0, stall_cnt}, m_stalls);
    chk("flush_cnt", {60'd0, flush_cnt}, m_flushes);
    if (m_data_known) begin
      chk("ex_rs1", {59'd0, ex_rs1}, {59'd0, m_rs1});
      chk("ex_rs2", {59'd0, ex_rs2}, {59'd0, m_rs2});
      chk("ex_rd", {59'd0, ex_rd}, {59'd0, m_rd});
      chk("ex_rdata1", ex_rdata1, m_rdata1);
      chk("ex_rdata2", ex_rdata2, m_rdata2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_pc", ex_pc, m_pc);
    end
  endtask

  task automatic idle();
    reset = 0; id_valid = 0; id_uses_rs2 = 0; id_mem_read = 0; id_reg_write = 0;
    wb_reg_write = 0; flush = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; wb_rd = 0;
    id_rdata1 = 0; id_rdata2 = 0; id_imm = 0; id_pc = 0; wb_data = 0; id_ctrl = 0;
  endtask

  task automatic randomize_inputs(input int reg_span);
    id_valid = ($urandom_range(0, 9) != 0);
    id_uses_rs2 = $urandom_range(0, 1);
    id_mem_read = ($urandom_range(0, 9) < 4);
    id_reg_write = $urandom_range(0, 1);
    wb_reg_write = $urandom_range(0, 1);
    id_rs1 = 5'($urandom_range(0, reg_span));
    id_rs2 = 5'($urandom_range(0, reg_span));
    id_rd = 5'($urandom_range(0, reg_span));
    wb_rd = 5'($urandom_range(0, reg_span));
    id_rdata1 = {$urandom, $urandom}; id_rdata2 = {$urandom, $urandom};
    id_imm = {$urandom, $urandom}; id_pc = {$urandom, $urandom};
    wb_data = {$urandom, $urandom}; id_ctrl = 8'($urandom);
  endtask

  task automatic load_into_ex(input logic [4:0] rd);
    idle(); id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = rd; id_ctrl = 8'h5A;
    step();
  endtask

  initial begin
    idle();
    m_valid = 0; m_mem_read = 0; m_reg_write = 0; m_ctrl = 0; m_data_known = 0;
    {m_rs1, m_rs2, m_rd, m_rdata1, m_rdata2, m_imm, m_pc} = '0;

    // Reset with random inputs on the pins
    @(negedge clk);
    repeat (2) begin randomize_inputs(31); reset = 1; flush = 0; step(); end
    chk("rst_valid", {63'd0, ex_valid}, 64'd0);
    chk("rst_rdata1", ex_rdata1, 64'd0);

    // Pass-through
    idle(); id_valid = 1; id_rs1 = 3; id_rdata1 = 64'h55; id_imm = -64'sd4; step();
    chk("pt_rdata1", ex_rdata1, 64'h55);
    chk("pt_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);

    // Load-use through rs2
    load_into_ex(5);
    idle(); id_valid = 1; id_rs1 = 1; id_rs2 = 5; id_uses_rs2 = 1; id_rdata2 = 64'h77; step();
    chk("lu_stall", {63'd0, obs_stall}, 64'd1);
    chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
    step();
    chk("lu_stall_gone", {63'd0, obs_stall}, 64'd0);
    chk("lu_enter_rs2", {59'd0, ex_rs2}, 64'd5);
    chk("lu_cnt", {60'd0, stall_cnt}, 64'd1);

    // Write-back bypass, including the x0 case
    idle(); id_valid = 1; wb_reg_write = 1; wb_rd = 7; wb_data = 64'hABC; id_rs1 = 7; step();
    chk("byp_rs1", ex_rdata1, 64'hABC);
    idle(); id_valid = 1; wb_reg_write = 1; wb_rd = 0; wb_data = 64'hABC; id_rs1 = 0;
    id_rdata1 = 64'h123; step();
    chk("byp_x0", ex_rdata1, 64'd0);

    // Flush beats a simultaneous hazard
    load_into_ex(9);
    idle(); id_valid = 1; id_rs1 = 9; flush = 1; step();
    chk("fl_stall", {63'd0, obs_stall}, 64'd0);
    chk("fl_valid", {63'd0, ex_valid}, 64'd0);
    chk("fl_fcnt", {60'd0, flush_cnt}, 64'd1);
    chk("fl_scnt", {60'd0, stall_cnt}, 64'd1);

    // Drive the 4-bit stall counter past its ceiling
    for (int i = 0; i < 17; i++) begin
      load_into_ex(5'(1 + i % 30));
      idle(); id_valid = 1; id_rs1 = 5'(1 + i % 30); step();
    end
    chk("sat_stall", {60'd0, stall_cnt}, CNT_MAX);

    // Reset in the middle of a stall
    load_into_ex(4);
    idle(); id_valid = 1; id_rs1 = 4; reset = 1; step();
    chk("rst_mid_stall", {63'd0, obs_stall}, 64'd0);
    chk("rst_mid_cnt", {60'd0, stall_cnt}, 64'd0);

    // Random traffic on a small register window so hazards and bypasses are common
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs(7);
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 10);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
